// File: rtl/rv32im_irq_pkg.sv
// +--------------------------------------------------------------------------+
// | rv32im_irq_pkg : register map, lane indices and helpers for irq controller |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package rv32im_irq_pkg;

    localparam logic [31:0] IRQ_BASE    = 32'h4004_0000;

    localparam logic [7:0]  IRQ_PENDING = 8'h00;
    localparam logic [7:0]  IRQ_ENABLE  = 8'h04;
    localparam logic [7:0]  IRQ_TYPE    = 8'h08;
    localparam logic [7:0]  IRQ_SWSET   = 8'h0C;
    localparam logic [7:0]  IRQ_CLAIM   = 8'h10;
    localparam logic [7:0]  IRQ_RAW     = 8'h14;
    localparam logic [7:0]  IRQ_MAP_END = 8'h18;

    localparam int unsigned IRQ_LANE_COMM  = 0;
    localparam int unsigned IRQ_LANE_TIMER = 1;
    localparam int unsigned IRQ_LANE_PWM   = 2;
    localparam int unsigned IRQ_LANE_ADC   = 3;
    localparam int unsigned IRQ_LANE_PROT  = 4;
    localparam int unsigned IRQ_LANE_WDT   = 5;
    localparam int unsigned IRQ_LANE_ESTOP = 6;
    localparam int unsigned IRQ_LANE_EXT0  = 8;

    localparam logic [0:0]  WB_IDLE = 1'b0;
    localparam logic [0:0]  WB_RESP = 1'b1;

    // Lane 0 has the highest priority, so the lowest set index wins.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        lowest_set = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set = 5'(i);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_sync_edge.sv
// +--------------------------------------------------------------------------+
// | irq_sync_edge : per-lane optional synchroniser plus rising-edge detector  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module irq_sync_edge #(
    parameter bit          ASYNC       = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src_i,
    output logic s_o,
    output logic rise_o
);

    logic prev_q;

    generate
        if (ASYNC) begin : g_async
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
                end
            end

            assign s_o = sync_q[SYNC_STAGES-1];
        end else begin : g_direct
            assign s_o = src_i;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= s_o;
        end
    end

    assign rise_o = s_o & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/irq_controller_macro.sv
// +--------------------------------------------------------------------------+
// | irq_controller_macro : IRQ aggregator with pending/enable/type regs,      |
// | fixed-priority claim and a one-wait-state Wishbone slave. Revision 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module irq_controller_macro
    import rv32im_irq_pkg::*;
#(
    parameter int unsigned        NUM_IRQ     = 16,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] ASYNC_MASK  = 16'hFF00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    input  logic               wb_we_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    output logic [NUM_IRQ-1:0] irq_vec_o,
    output logic               irq_o,
    output logic [4:0]         irq_id_o
);

    logic [NUM_IRQ-1:0] s_w;
    logic [NUM_IRQ-1:0] rise_w;

    generate
        for (genvar i = 0; i < NUM_IRQ; i++) begin : g_lane
            irq_sync_edge #(
                .ASYNC       (ASYNC_MASK[i]),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .src_i  (irq_src_i[i]),
                .s_o    (s_w[i]),
                .rise_o (rise_w[i])
            );
        end
    endgenerate

    logic [0:0]         state_q, state_d;
    logic               accept_w, commit_w, wr_ok_w, claim_w;
    logic               req_we_q, req_full_q, req_err_q;
    logic [5:0]         req_off_q;
    logic [NUM_IRQ-1:0] req_dat_q;
    logic [31:0]        dat_q, rd_w;
    logic [NUM_IRQ-1:0] pend_q, pend_d, en_q, type_q;
    logic [NUM_IRQ-1:0] set_w, clr_w, vec_d;
    logic               unused_bus;

    assign unused_bus = ^{wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign accept_w = (state_q == WB_IDLE) && wb_cyc_i && wb_stb_i && !wb_ack_o;

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: if (accept_w) state_d = WB_RESP;
            WB_RESP: state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        wb_ack_o = 1'b0;
        wb_err_o = 1'b0;
        if (state_q == WB_RESP) begin
            wb_ack_o = ~req_err_q;
            wb_err_o =  req_err_q;
        end
    end

    always_comb begin
        rd_w = 32'd0;
        case (wb_adr_i[7:2])
            IRQ_PENDING[7:2]: rd_w = 32'(pend_q);
            IRQ_ENABLE[7:2]:  rd_w = 32'(en_q);
            IRQ_TYPE[7:2]:    rd_w = 32'(type_q);
            IRQ_CLAIM[7:2]:   rd_w = {irq_o, 26'd0, irq_id_o};
            IRQ_RAW[7:2]:     rd_w = 32'(s_w);
            default:          rd_w = 32'd0;
        endcase
    end

    // The request is captured at accept so side effects fire exactly once at
    // the ack edge, even if the master drops cyc in the response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we_q   <= 1'b0;
            req_full_q <= 1'b0;
            req_err_q  <= 1'b0;
            req_off_q  <= '0;
            req_dat_q  <= '0;
            dat_q      <= '0;
        end else if (accept_w) begin
            req_we_q   <= wb_we_i;
            req_full_q <= (wb_sel_i == 4'hF);
            req_err_q  <= (wb_adr_i[7:2] >= IRQ_MAP_END[7:2]);
            req_off_q  <= wb_adr_i[7:2];
            req_dat_q  <= wb_dat_i[NUM_IRQ-1:0];
            dat_q      <= rd_w;
        end
    end

    assign wb_dat_o = dat_q;
    assign commit_w = (state_q == WB_RESP);
    assign wr_ok_w  = commit_w && req_we_q && req_full_q;
    assign claim_w  = commit_w && !req_we_q && (req_off_q == IRQ_CLAIM[7:2]) && dat_q[31];

    always_comb begin
        set_w = rise_w;
        clr_w = '0;
        if (wr_ok_w && (req_off_q == IRQ_SWSET[7:2]))   set_w = set_w | req_dat_q;
        if (wr_ok_w && (req_off_q == IRQ_PENDING[7:2])) clr_w = clr_w | req_dat_q;
        if (claim_w) clr_w = clr_w | (NUM_IRQ'(1) << dat_q[4:0]);
    end

    // Set has priority over clear; level lanes simply track the live input.
    assign pend_d = (type_q & (set_w | (pend_q & ~clr_w))) | (~type_q & s_w);
    assign vec_d  = pend_q & en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            en_q      <= '0;
            type_q    <= '0;
            irq_vec_o <= '0;
            irq_o     <= 1'b0;
            irq_id_o  <= 5'd0;
        end else begin
            pend_q    <= pend_d;
            irq_vec_o <= vec_d;
            irq_o     <= |vec_d;
            irq_id_o  <= lowest_set(32'(vec_d));
            if (wr_ok_w && (req_off_q == IRQ_ENABLE[7:2])) en_q   <= req_dat_q;
            if (wr_ok_w && (req_off_q == IRQ_TYPE[7:2]))   type_q <= req_dat_q;
        end
    end

endmodule

`default_nettype wire
